// File: rtl/spi_frame_sequencer.sv
// SPI frame sequencer: synchronizes SPI slave byte/select events into clk_root and
// decodes opcode/address/data frames into buffer write strobes.
module spi_frame_sequencer #(
   parameter int         ADDR_WIDTH = 12,
   parameter logic [7:0] OP_WRITE   = 8'h57,
   parameter logic [7:0] OP_NOP     = 8'h00
) (
   input  logic                  clk_root,
   input  logic                  reset,
   input  logic                  spi_ss,
   input  logic                  spi_done,
   input  logic [7:0]            spi_rdata,
   output logic [7:0]            spi_tdata,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [7:0]            wr_data,
   output logic                  frame_active,
   output logic                  frame_done,
   output logic [7:0]            err_count,
   output logic [3:0]            dbg_state
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      CMD     = 4'd1,
      ADDR_HI = 4'd2,
      ADDR_LO = 4'd3,
      DATA    = 4'd4,
      DISCARD = 4'd5
   } state_t;

   state_t                state, state_after, state_next;
   logic                  done_s1, done_s2, done_s3;
   logic                  ss_s1, ss_s2, ss_s3;
   logic                  strobe, frame_start, frame_end;
   logic                  ld_hi, ld_lo, wr_fire, err_inc;
   logic [7:0]            byte_q;
   logic [7:0]            tdata_next;
   logic [ADDR_WIDTH-1:0] addr;

   assign strobe      = done_s2 & ~done_s3;
   assign frame_start = ~ss_s2 & ss_s3;
   assign frame_end   = ss_s2 & ~ss_s3;
   assign wr_data     = byte_q;
   assign dbg_state   = state;

   // Byte decode runs first (state_after); frame-end then overrides, so a byte that
   // lands in the same cycle as the select release is still honoured.
   always_comb begin
      state_after = state;
      state_next  = state;
      ld_hi       = 1'b0;
      ld_lo       = 1'b0;
      wr_fire     = 1'b0;
      err_inc     = 1'b0;
      tdata_next  = 8'h00;
      case (state)
         IDLE: if (frame_start) state_after = CMD;
         CMD: begin
            if (strobe) begin
               if (spi_rdata == OP_WRITE) begin
                  state_after = ADDR_HI;
               end else begin
                  state_after = DISCARD;
                  err_inc     = (spi_rdata != OP_NOP);
               end
            end
         end
         ADDR_HI: begin
            if (strobe) begin
               ld_hi       = 1'b1;
               state_after = ADDR_LO;
            end
         end
         ADDR_LO: begin
            if (strobe) begin
               ld_lo       = 1'b1;
               state_after = DATA;
            end
         end
         DATA:    wr_fire = strobe;
         DISCARD: state_after = DISCARD;
         default: state_after = IDLE;
      endcase
      state_next = state_after;
      if (frame_end) begin
         state_next = IDLE;
         if (state_after == CMD || state_after == ADDR_HI || state_after == ADDR_LO)
            err_inc = 1'b1;
      end
      case (state_next)
         CMD:     tdata_next = 8'hA5;
         DATA:    tdata_next = wr_fire ? spi_rdata : {4'h0, DATA};
         default: tdata_next = {4'h0, state_next};
      endcase
   end

   always_ff @(posedge clk_root or posedge reset) begin
      if (reset) begin
         done_s1      <= 1'b0;
         done_s2      <= 1'b0;
         done_s3      <= 1'b0;
         ss_s1        <= 1'b1;
         ss_s2        <= 1'b1;
         ss_s3        <= 1'b1;
         state        <= IDLE;
         byte_q       <= 8'h00;
         addr         <= '0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         frame_done   <= 1'b0;
         frame_active <= 1'b0;
         err_count    <= 8'h00;
         spi_tdata    <= 8'h00;
      end else begin
         done_s1      <= spi_done;
         done_s2      <= done_s1;
         done_s3      <= done_s2;
         ss_s1        <= spi_ss;
         ss_s2        <= ss_s1;
         ss_s3        <= ss_s2;
         state        <= state_next;
         wr_en        <= wr_fire;
         frame_done   <= frame_end;
         frame_active <= (state_next != IDLE);
         if (strobe) byte_q <= spi_rdata;
         // High address bits beyond ADDR_WIDTH fall off in the shift.
         if (ld_hi) addr <= (ADDR_WIDTH'(spi_rdata) << 8) | (addr & ADDR_WIDTH'(8'hFF));
         if (ld_lo) addr <= (addr & ~ADDR_WIDTH'(8'hFF)) | ADDR_WIDTH'(spi_rdata);
         if (wr_fire) begin
            wr_addr <= addr;
            addr    <= addr + ADDR_WIDTH'(1);
         end
         if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
         if (strobe || state_next != state) spi_tdata <= tdata_next;
      end
   end

endmodule
